// File: rtl/softmax_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// softmax_ctrl_pkg
// Shared definitions for the softmax job controller:
//   - state_e        : job sequencer states
//   - START_CODE_DEF : default GPIO byte that launches a job
//   - DST_BASE_DEF   : default first result word address in the output BRAM
//   - FRAC_W / Q_ONE : Q4.12 probability format of the result words
//                      (result word = {index[15:0], probability Q4.12})
// No ports (package).
// -----------------------------------------------------------------------------
package softmax_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [7:0]  START_CODE_DEF = 8'hAA;
   localparam int unsigned DST_BASE_DEF   = 131072;

   localparam int unsigned FRAC_W = 12;
   localparam logic [15:0] Q_ONE  = 16'(1 << FRAC_W);

endpackage

// File: rtl/softmax_start_detect.sv
// -----------------------------------------------------------------------------
// softmax_start_detect
// Turns a level GPIO code into a one-cycle start pulse. The pulse fires on the
// first cycle the code matches; holding the code does not retrigger, clearing
// it and writing it again does.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset (clears the match history)
//   code  : GPIO byte to decode
//   start : one-cycle start pulse (combinational from code and history)
// -----------------------------------------------------------------------------
module softmax_start_detect
   import softmax_ctrl_pkg::*;
#(
   parameter logic [7:0] START_CODE = START_CODE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] code,
   output logic       start
);

   logic match;
   logic prev_match;

   assign match = (code == START_CODE);
   assign start = match && !prev_match;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_match <= 1'b0;
      end else begin
         prev_match <= match;
      end
   end

endmodule

// File: rtl/softmax_job_ctrl.sv
// -----------------------------------------------------------------------------
// softmax_job_ctrl
// Sequences one softmax job over the output BRAM. A GPIO start code launches
// the job, which is split into ROWS row commands (source, destination, length)
// for the load/fetch engine. At most MAX_OUT commands are outstanding; row
// completions are counted and busy/done/error are reported back.
//
// Optional feature (macro SOFTMAX_JOB_CTRL_TIMEOUT_EN): a watchdog counts
// cycles while busy, cleared on every handshake and row completion. Reaching
// TMO_CYC aborts the job with error=1, done=0, busy=0.
//
// Ports:
//   aclk      : clock
//   rst_n     : synchronous active-low reset
//   gpio_io_o : GPIO word, only [7:0] decoded as the start code
//   cmd_valid : row command valid (registered, held until accepted)
//   cmd_ready : engine accepts the command
//   cmd_src   : row source word address (wraps modulo 2^ADDR_W)
//   cmd_dst   : row destination word address (wraps modulo 2^ADDR_W)
//   cmd_len   : words per row, constant ROW_LEN
//   row_done  : one-cycle pulse per completed row
//   busy      : job in progress
//   done      : job complete, sticky until the next start
//   error     : protocol error (or watchdog), sticky until the next start
//   rows_done : completed-row counter
// -----------------------------------------------------------------------------
module softmax_job_ctrl
   import softmax_ctrl_pkg::*;
#(
   parameter int unsigned ROWS       = 4800,
   parameter int unsigned ROW_LEN    = 10,
   parameter int unsigned ADDR_W     = 18,
   parameter int unsigned SRC_BASE   = 0,
   parameter int unsigned DST_BASE   = DST_BASE_DEF,
   parameter int unsigned MAX_OUT    = 2,
   parameter logic [7:0]  START_CODE = START_CODE_DEF
`ifdef SOFTMAX_JOB_CTRL_TIMEOUT_EN
   ,
   parameter int unsigned TMO_CYC    = 65535
`endif
) (
   input  logic              aclk,
   input  logic              rst_n,
   input  logic [31:0]       gpio_io_o,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [ADDR_W-1:0] cmd_src,
   output logic [ADDR_W-1:0] cmd_dst,
   output logic [15:0]       cmd_len,
   input  logic              row_done,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [15:0]       rows_done
);

   localparam int unsigned PROD_W    = ADDR_W + 16;
   localparam logic [15:0] ROWS_C    = 16'(ROWS);
   localparam logic [2:0]  MAX_OUT_C = 3'(MAX_OUT);

   state_e            state, state_n;
   logic [15:0]       issue_idx, idx_n;
   logic [15:0]       rows_n;
   logic [2:0]        outstanding, out_n;
   logic              busy_n, done_n, error_n, valid_n;
   logic              start, hs, counted;
   logic [PROD_W-1:0] src_full, dst_full;
   logic              unused_gpio;

   assign unused_gpio = ^gpio_io_o[31:8];
   assign cmd_len     = 16'(ROW_LEN);

   softmax_start_detect #(
      .START_CODE (START_CODE)
   ) u_start_detect (
      .clk   (aclk),
      .rst_n (rst_n),
      .code  (gpio_io_o[7:0]),
      .start (start)
   );

   assign hs = cmd_valid && cmd_ready;
   // A completion is only legal against an outstanding command; one that
   // coincides with a handshake pairs with the command just accepted.
   assign counted = row_done && ((outstanding != 3'd0) || hs);

   // Addresses follow the index the command register will hold next cycle.
   assign src_full = PROD_W'(SRC_BASE) + PROD_W'(idx_n) * PROD_W'(ROW_LEN);
   assign dst_full = PROD_W'(DST_BASE) + PROD_W'(idx_n) * PROD_W'(ROW_LEN);

`ifdef SOFTMAX_JOB_CTRL_TIMEOUT_EN
   logic [31:0] wd, wd_n;
`endif

   always_comb begin
      state_n = state;
      idx_n   = issue_idx;
      out_n   = outstanding;
      rows_n  = rows_done;
      busy_n  = busy;
      done_n  = done;
      error_n = error;
      case (state)
         ISSUE, DRAIN: begin
            if (hs) idx_n = issue_idx + 16'd1;
            if (counted) rows_n = rows_done + 16'd1;
            else if (row_done) error_n = 1'b1;
            out_n = outstanding + {2'b00, hs} - {2'b00, counted};
            if (idx_n == ROWS_C) begin
               // The last completion may land in the same cycle as the last
               // handshake, so the finish check covers both states.
               if (rows_n == ROWS_C) begin
                  state_n = DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  state_n = DRAIN;
               end
            end
         end
         default: begin
            if (start) begin
               state_n = ISSUE;
               idx_n   = 16'd0;
               rows_n  = 16'd0;
               out_n   = 3'd0;
               busy_n  = 1'b1;
               done_n  = 1'b0;
               error_n = 1'b0;
            end
         end
      endcase
`ifdef SOFTMAX_JOB_CTRL_TIMEOUT_EN
      if (!busy || hs || row_done) wd_n = 32'd0;
      else wd_n = wd + 32'd1;
      if (busy && (wd_n == TMO_CYC)) begin
         state_n = DONE;
         busy_n  = 1'b0;
         done_n  = 1'b0;
         error_n = 1'b1;
         wd_n    = 32'd0;
      end
`endif
      // Once raised, the terms below cannot fall without a handshake
      // (outstanding only shrinks), so the command is never retracted.
      valid_n = (state_n == ISSUE) && (idx_n < ROWS_C) && (out_n < MAX_OUT_C);
   end

   always_ff @(posedge aclk) begin
      if (!rst_n) begin
         state       <= IDLE;
         issue_idx   <= 16'd0;
         outstanding <= 3'd0;
         rows_done   <= 16'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         cmd_valid   <= 1'b0;
         cmd_src     <= '0;
         cmd_dst     <= '0;
`ifdef SOFTMAX_JOB_CTRL_TIMEOUT_EN
         wd          <= 32'd0;
`endif
      end else begin
         state       <= state_n;
         issue_idx   <= idx_n;
         outstanding <= out_n;
         rows_done   <= rows_n;
         busy        <= busy_n;
         done        <= done_n;
         error       <= error_n;
         cmd_valid   <= valid_n;
         if (state_n == ISSUE) begin
            cmd_src <= src_full[ADDR_W-1:0];
            cmd_dst <= dst_full[ADDR_W-1:0];
         end
`ifdef SOFTMAX_JOB_CTRL_TIMEOUT_EN
         wd          <= wd_n;
`endif
      end
   end

endmodule

// File: tb/tb_softmax_job_ctrl.sv
// -----------------------------------------------------------------------------
// tb_softmax_job_ctrl
// Self-checking bench for softmax_job_ctrl (ROWS=4, ROW_LEN=10, MAX_OUT=2).
// A negedge responder process drives cmd_ready (random mode) and row_done
// (delayed completions, optional stray pulses) and keeps a reference model of
// accepted commands, outstanding count, completions and expected error.
// -----------------------------------------------------------------------------
module tb_softmax_job_ctrl;

   localparam int          ROWS     = 4;
   localparam int          ROW_LEN  = 10;
   localparam int          ADDR_W   = 18;
   localparam int          MAX_OUT  = 2;
   localparam logic [7:0]  CODE     = 8'hAA;
`ifdef SOFTMAX_JOB_CTRL_TIMEOUT_EN
   localparam int          TMO      = 50;
   localparam int          HOLD_CYC = 40;
`else
   localparam int          HOLD_CYC = 100;
`endif

   typedef struct {
      int                idx;
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] dst;
   } cmd_vec_t;

   cmd_vec_t tab [ROWS];

   logic              aclk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       gpio = 32'd0;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_src;
   logic [ADDR_W-1:0] cmd_dst;
   logic [15:0]       cmd_len;
   logic              row_done;
   logic              busy;
   logic              done;
   logic              error;
   logic [15:0]       rows_done;

   // main-driven controls
   logic man_ready = 1'b0;
   logic man_rd    = 1'b0;
   logic rnd_en    = 1'b0;
   logic spur_en   = 1'b0;
   logic auto_done = 1'b0;
   int   job_seq   = 0;

   // responder-driven stimulus and model state
   logic              rnd_ready = 1'b0;
   logic              auto_rd   = 1'b0;
   int                cyc = 0;
   int                seen_seq = 0;
   int                pend [$];
   int                last_due = 0;
   int                mdl_out = 0, mdl_peak = 0, mdl_cnt = 0;
   logic              mdl_err = 1'b0, mdl_active = 1'b0, arm = 1'b0;
   logic [ADDR_W-1:0] hs_src [$];
   logic [ADDR_W-1:0] hs_dst [$];
   int                n_hs = 0;
   int                last_rd_cyc = 0, done_cyc = 0;
   logic              done_seen = 1'b0;
   int                hold_viol = 0;
   logic              prev_stall = 1'b0;
   logic [ADDR_W-1:0] prev_src = '0, prev_dst = '0;

   int n_cmp = 0;
   int n_fail = 0;

   assign cmd_ready = rnd_en ? rnd_ready : man_ready;
   assign row_done  = auto_rd | man_rd;

   always #5 aclk = ~aclk;

   softmax_job_ctrl #(
      .ROWS       (ROWS),
      .ROW_LEN    (ROW_LEN),
      .ADDR_W     (ADDR_W),
      .SRC_BASE   (0),
      .DST_BASE   (131072),
      .MAX_OUT    (MAX_OUT),
      .START_CODE (CODE)
`ifdef SOFTMAX_JOB_CTRL_TIMEOUT_EN
      ,
      .TMO_CYC    (TMO)
`endif
   ) dut (
      .aclk      (aclk),
      .rst_n     (rst_n),
      .gpio_io_o (gpio),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .cmd_len   (cmd_len),
      .row_done  (row_done),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .rows_done (rows_done)
   );

   // Responder + reference model, evaluated mid-cycle so everything it sees
   // and drives is settled before the next rising edge.
   initial begin : resp
      int   due;
      logic rdy, hsm, rd_pend, spur, rd_all, cnt;
      forever begin
         @(negedge aclk);
         cyc++;
         if (rnd_en) rnd_ready = ($urandom_range(0, 1) == 1);
         rdy = rnd_en ? rnd_ready : man_ready;
         if (job_seq != seen_seq) begin
            seen_seq = job_seq;
            pend.delete();
            last_due = 0;
            mdl_out = 0; mdl_peak = 0; mdl_cnt = 0; mdl_err = 1'b0;
            mdl_active = 1'b0; arm = 1'b1;
            hs_src.delete(); hs_dst.delete(); n_hs = 0;
            done_seen = 1'b0; done_cyc = 0; last_rd_cyc = 0;
         end else if (arm) begin
            mdl_active = 1'b1;
            arm = 1'b0;
         end
         if (!rst_n) begin
            pend.delete();
            mdl_out = 0; mdl_active = 1'b0; arm = 1'b0;
            prev_stall = 1'b0;
            auto_rd = 1'b0;
         end else begin
            if (!done_seen && mdl_cnt == ROWS && done && cyc > last_rd_cyc) begin
               done_seen = 1'b1;
               done_cyc  = cyc;
            end
            hsm = cmd_valid && rdy;
            if (prev_stall && !(cmd_valid && cmd_src == prev_src && cmd_dst == prev_dst))
               hold_viol++;
            prev_stall = cmd_valid && !rdy;
            prev_src   = cmd_src;
            prev_dst   = cmd_dst;
            rd_pend = 1'b0;
            spur    = 1'b0;
            if (pend.size() > 0 && pend[0] <= cyc) begin
               void'(pend.pop_front());
               rd_pend = 1'b1;
            end else if (spur_en && mdl_active && mdl_out == 0 && !hsm && !man_rd &&
                         $urandom_range(0, 15) == 0) begin
               spur = 1'b1;
            end
            auto_rd = rd_pend | spur;
            rd_all  = auto_rd | man_rd;
            if (hsm) begin
               hs_src.push_back(cmd_src);
               hs_dst.push_back(cmd_dst);
               n_hs++;
               if (auto_done) begin
                  due = cyc + (rnd_en ? int'($urandom_range(1, 8)) : 5);
                  if (due <= last_due) due = last_due + 1;
                  last_due = due;
                  pend.push_back(due);
               end
            end
            if (mdl_active) begin
               cnt = rd_all && (mdl_out > 0 || hsm);
               if (rd_all && !cnt) mdl_err = 1'b1;
               if (cnt) begin
                  mdl_cnt++;
                  last_rd_cyc = cyc;
               end
               mdl_out = mdl_out + (hsm ? 1 : 0) - (cnt ? 1 : 0);
               if (mdl_out > mdl_peak) mdl_peak = mdl_out;
               if (mdl_cnt == ROWS) mdl_active = 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic start_job();
      gpio = 32'd0;
      tick();
      gpio = {24'($urandom), CODE};
      job_seq++;
      tick();
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!done && k < 400) begin
         tick();
         k++;
      end
   endtask

   task automatic check_job(input string name, input logic exp_err);
      logic [ADDR_W-1:0] a;
      tick();
      check({name, "_nhs"}, n_hs, ROWS);
      for (int i = 0; i < ROWS; i++) begin
         a = (tab[i].idx < hs_src.size()) ? hs_src[tab[i].idx] : '1;
         check($sformatf("%s_src%0d", name, i), a, tab[i].src);
         a = (tab[i].idx < hs_dst.size()) ? hs_dst[tab[i].idx] : '1;
         check($sformatf("%s_dst%0d", name, i), a, tab[i].dst);
      end
      check({name, "_peak_le_max"}, (mdl_peak <= MAX_OUT), 1);
      check({name, "_rows_done"}, rows_done, ROWS);
      check({name, "_done"}, done, 1);
      check({name, "_busy"}, busy, 0);
      check({name, "_error"}, error, exp_err);
      check({name, "_done_lat"}, done_cyc, last_rd_cyc + 1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      int                k, bad;
      logic [ADDR_W-1:0] s_src, s_dst;

      tab[0] = '{0, 18'd0,  18'd131072};
      tab[1] = '{1, 18'd10, 18'd131082};
      tab[2] = '{2, 18'd20, 18'd131092};
      tab[3] = '{3, 18'd30, 18'd131102};

      // reset state
      tick();
      tick();
      check("rst_valid", cmd_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_rows", rows_done, 0);
      check("rst_src", cmd_src, 0);
      check("rst_dst", cmd_dst, 0);
      check("rst_len", cmd_len, ROW_LEN);
      rst_n = 1'b1;
      tick();

      // basic job: ready always high, completions 5 cycles after each accept
      auto_done = 1'b1;
      man_ready = 1'b1;
      start_job();
      check("first_valid", cmd_valid, 1);
      check("first_busy", busy, 1);
      wait_done();
      check_job("basic", 1'b0);

      // back-pressure: 20 stalled cycles, then a single-cycle ready
      man_ready = 1'b0;
      start_job();
      check("stall_valid", cmd_valid, 1);
      s_src = cmd_src;
      s_dst = cmd_dst;
      bad = 0;
      repeat (20) begin
         tick();
         if (!(cmd_valid && cmd_src == s_src && cmd_dst == s_dst)) bad++;
      end
      check("stall_stable", bad, 0);
      man_ready = 1'b1;
      tick();
      man_ready = 1'b0;
      tick();
      tick();
      check("stall_one_hs", n_hs, 1);
      man_ready = 1'b1;
      wait_done();
      check_job("stall", 1'b0);

      // stray completion with nothing outstanding
      man_ready = 1'b0;
      start_job();
      tick();
      man_rd = 1'b1;
      tick();
      man_rd = 1'b0;
      check("spur_error", error, 1);
      check("spur_rows", rows_done, 0);
      man_ready = 1'b1;
      wait_done();
      check_job("spur", 1'b1);

      // code held, then rewritten mid-job: only one job runs
      man_ready = 1'b0;
      gpio = 32'd0;
      tick();
      gpio = {24'd0, CODE};
      job_seq++;
      repeat (HOLD_CYC) tick();
      check("hold_busy", busy, 1);
      man_ready = 1'b1;
      tick();
      man_ready = 1'b0;
      gpio = 32'd0;
      tick();
      gpio = {24'd0, CODE};
      tick();
      tick();
      man_ready = 1'b1;
      wait_done();
      check_job("retrig", 1'b0);
      repeat (30) tick();
      check("retrig_idle_busy", busy, 0);
      check("retrig_idle_done", done, 1);
      check("retrig_idle_nhs", n_hs, ROWS);

      // reset after the second accepted command
      man_ready = 1'b1;
      start_job();
      k = 0;
      while (n_hs < 2 && k < 50) begin
         tick();
         k++;
      end
      check("rst_mid_reached_hs2", n_hs, 2);
      rst_n = 1'b0;
      gpio  = 32'd0;
      tick();
      rst_n = 1'b1;
      check("rst_mid_valid", cmd_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_error", error, 0);
      check("rst_mid_rows", rows_done, 0);
      check("rst_mid_src", cmd_src, 0);
      check("rst_mid_dst", cmd_dst, 0);
      check("rst_mid_len", cmd_len, ROW_LEN);
      repeat (10) tick();
      check("rst_idle_valid", cmd_valid, 0);
      check("rst_idle_busy", busy, 0);
      start_job();
      check("fresh_src", cmd_src, 0);
      wait_done();
      check_job("fresh", 1'b0);

      // randomized back-pressure, completion delays and stray completions
      rnd_en  = 1'b1;
      spur_en = 1'b1;
      for (int j = 0; j < 4; j++) begin
         start_job();
         wait_done();
         check_job($sformatf("rnd%0d", j), mdl_err);
      end
      rnd_en  = 1'b0;
      spur_en = 1'b0;
      check("axi_hold", hold_viol, 0);

`ifdef SOFTMAX_JOB_CTRL_TIMEOUT_EN
      // watchdog: no completions ever arrive
      auto_done = 1'b0;
      man_ready = 1'b1;
      start_job();
      k = 0;
      while (n_hs < 2 && k < 50) begin
         tick();
         k++;
      end
      check("tmo_hs2", n_hs, 2);
      repeat (TMO - 1) tick();
      check("tmo_pre_error", error, 0);
      check("tmo_pre_busy", busy, 1);
      tick();
      check("tmo_error", error, 1);
      check("tmo_busy", busy, 0);
      check("tmo_done", done, 0);
      check("tmo_valid", cmd_valid, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/softmax_job_ctrl.md
Name: softmax_job_ctrl

Overview:
Sequences one softmax job across the output BRAM, triggered by the GPIO start code. Splits the job into ROWS row commands for the load/fetch engine, each with source/destination BRAM word addresses and a length. Keeps up to MAX_OUT commands in flight and counts row completions. Reports busy/done/error status back to the GPIO/status path.

Parameters:
- ROWS, 4800, rows per job.
- ROW_LEN, 10, 32-bit words per row; must be at least 1.
- ADDR_W, 18, BRAM word-address width.
- SRC_BASE, 0, first source word address.
- DST_BASE, 131072, first result word address. Result word format: [31:16] index, [15:0] Q4.12 probability.
- MAX_OUT, 2, maximum outstanding row commands, 1..4.
- START_CODE, 8'hAA, gpio[7:0] value that starts a job.
- TMO_CYC, 65535, watchdog limit in cycles (optional feature only).

Ports:
- aclk, in, 1, clock.
- rst_n, in, 1, reset; synchronous, active-low.
- gpio_io_o, in, 32, GPIO output word; only bits [7:0] are decoded.
- cmd_valid, out, 1, row command valid.
- cmd_ready, in, 1, load/fetch engine accepts the command.
- cmd_src, out, ADDR_W, row source address.
- cmd_dst, out, ADDR_W, row destination address.
- cmd_len, out, 16, ROW_LEN.
- row_done, in, 1, one-cycle pulse per completed row (s2mm tlast beat).
- busy, out, 1, job in progress.
- done, out, 1, job complete; sticky.
- error, out, 1, protocol error; sticky.
- rows_done, out, 16, completed-row counter.

Behaviour:
- Reset (rst_n=0 sampled at a rising aclk edge):
  - FSM goes to IDLE.
  - All outputs 0, except cmd_len, which is constant ROW_LEN.
  - Outstanding count, issue index and start-detect history cleared.
  - Applies mid-job too: no further commands are issued, and any late row_done pulses are ignored while rst_n=0.
- Start detect:
  - start = (gpio_io_o[7:0]==START_CODE) && !prev_match. prev_match is registered.
  - Holding the code does not retrigger. Returning to 0 and re-writing the code retriggers.
  - Start is acted on only in IDLE or DONE; start in any other state is ignored.
- States:
  - IDLE / DONE --start--> ISSUE. On this transition: issue_idx=0, rows_done=0, outstanding=0, done=0, error=0, busy=1.
  - ISSUE: cmd_valid=1 when issue_idx<ROWS and outstanding<MAX_OUT.
    - cmd_src = SRC_BASE + issue_idx*ROW_LEN; cmd_dst = DST_BASE + issue_idx*ROW_LEN. Both are truncated to ADDR_W, so addresses wrap modulo 2^ADDR_W.
    - Handshake occurs when cmd_valid && cmd_ready in the same cycle; it increments issue_idx and outstanding.
    - cmd_valid is registered. Once asserted, cmd_valid and the address fields stay stable until the handshake (AXI-style; no retraction).
    - Transition to DRAIN when issue_idx reaches ROWS.
  - DRAIN: wait until rows_done==ROWS, then go to DONE with busy=0 and done=1.
- Completion handling (ISSUE and DRAIN):
  - row_done decrements outstanding and increments rows_done.
  - A handshake and row_done in the same cycle leave outstanding unchanged.
  - row_done with outstanding==0 (and no handshake that cycle): sets error, counts nothing, FSM continues.
  - row_done in IDLE/DONE: ignored, no error.
- Latency:
  - First cmd_valid is asserted 1 cycle after the cycle start is detected.
  - done is asserted 1 cycle after the final row_done.
- Width rules:
  - issue_idx and rows_done are 16 bit; ROWS ≤ 65535.
  - Address products are computed at ADDR_W+16 bits, then truncated.

Optional Feature:
- Macro: SOFTMAX_JOB_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs while busy. It is cleared on every handshake and every row_done.
  - On reaching TMO_CYC: set error, deassert cmd_valid, go to DONE with done=0, busy=0.
- Undefined: no counter; the block waits indefinitely and TMO_CYC is unused.

Decomposition:
- Package softmax_ctrl_pkg:
  - state enum: IDLE, ISSUE, DRAIN, DONE;
  - START_CODE default;
  - DST_BASE default;
  - Q4.12 constants (FRAC_W=12).
- Sub-module softmax_start_detect: code match plus rising-edge register; outputs a one-cycle start pulse.

Test Plan:
- ROWS=4, ROW_LEN=10, cmd_ready=1, row_done pulsed 5 cycles after each handshake, gpio 0 → 0xAA:
  - 4 commands: src 0/10/20/30, dst 131072/131082/131092/131102;
  - never more than 2 outstanding;
  - done=1, rows_done=4, error=0.
- cmd_ready held 0 for 20 cycles while cmd_valid=1: cmd_valid and cmd_src/cmd_dst are stable all 20 cycles; exactly one handshake when ready rises.
- row_done pulsed while outstanding=0 during ISSUE: error=1; rows_done unchanged; job still completes after the 4 real completions.
- gpio held at 0xAA for 100 cycles, then rewritten to 0xAA mid-job: exactly one job runs; the second start is ignored.
- rst_n=0 for 1 cycle after the 2nd handshake: next cycle all outputs 0 and state IDLE; a later 0→0xAA starts fresh with cmd_src=0.
- With SOFTMAX_JOB_CTRL_TIMEOUT_EN defined, TMO_CYC=50, row_done never pulsed: error=1 and busy=0 exactly 50 cycles after the last handshake; done=0.
